// File: rtl/vga_timing_pkg.sv
// Shared types, default 640x480@60 raster constants and line/frame total helpers
// for the VGA timing generator.
package vga_timing_pkg;

  typedef logic [31:0] coord_t;

  localparam coord_t DEF_H_ACTIVE = 32'd640;
  localparam coord_t DEF_H_FP     = 32'd16;
  localparam coord_t DEF_H_SYNC   = 32'd96;
  localparam coord_t DEF_H_BP     = 32'd48;
  localparam coord_t DEF_V_ACTIVE = 32'd480;
  localparam coord_t DEF_V_FP     = 32'd10;
  localparam coord_t DEF_V_SYNC   = 32'd2;
  localparam coord_t DEF_V_BP     = 32'd33;
  localparam logic   DEF_HS_POL   = 1'b0;
  localparam logic   DEF_VS_POL   = 1'b0;
  localparam coord_t DEF_PIX_DIV  = 32'd4;

  function automatic coord_t axis_total(input coord_t active, input coord_t fp,
                                        input coord_t sync, input coord_t bp);
    return active + fp + sync + bp;
  endfunction

  function automatic coord_t h_total(input coord_t active, input coord_t fp,
                                     input coord_t sync, input coord_t bp);
    return axis_total(active, fp, sync, bp);
  endfunction

  function automatic coord_t v_total(input coord_t active, input coord_t fp,
                                     input coord_t sync, input coord_t bp);
    return axis_total(active, fp, sync, bp);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: counts 0..TOTAL-1, stepping when en & wrap_in, and flags the
// step that wraps plus the sync-pulse window for the current count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter coord_t ACTIVE = DEF_H_ACTIVE,
  parameter coord_t FP     = DEF_H_FP,
  parameter coord_t SYNC   = DEF_H_SYNC,
  parameter coord_t BP     = DEF_H_BP
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  logic   wrap_in,
  output coord_t count,
  output logic   wrap_out,
  output logic   sync_window
);

  localparam coord_t TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
  localparam coord_t SYNC_START = ACTIVE + FP;
  localparam coord_t SYNC_END   = ACTIVE + FP + SYNC;

  coord_t count_r;
  logic   step_s;
  logic   last_s;

  assign step_s = en & wrap_in;
  assign last_s = (count_r == TOTAL - 32'd1);

  // Position counter, wrapping to zero after the last position of the axis.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= 32'd0;
    end else if (step_s) begin
      if (last_s) begin
        count_r <= 32'd0;
      end else begin
        count_r <= count_r + 32'd1;
      end
    end
  end

  assign count       = count_r;
  assign wrap_out    = step_s & last_s;
  assign sync_window = (count_r >= SYNC_START) && (count_r < SYNC_END);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: registered x/y/active/sync/start strobes, one tick late.
// Optional pixel-clock divider enabled by defining VGA_PIX_DIV_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
`ifdef VGA_PIX_DIV_EN
  parameter coord_t PIX_DIV  = DEF_PIX_DIV,
`endif
  parameter coord_t H_ACTIVE = DEF_H_ACTIVE,
  parameter coord_t H_FP     = DEF_H_FP,
  parameter coord_t H_SYNC   = DEF_H_SYNC,
  parameter coord_t H_BP     = DEF_H_BP,
  parameter coord_t V_ACTIVE = DEF_V_ACTIVE,
  parameter coord_t V_FP     = DEF_V_FP,
  parameter coord_t V_SYNC   = DEF_V_SYNC,
  parameter coord_t V_BP     = DEF_V_BP,
  parameter logic   HS_POL   = DEF_HS_POL,
  parameter logic   VS_POL   = DEF_VS_POL
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] x,
  output logic [31:0] y,
  output logic        active,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start,
  output logic        pix_valid
);

  logic   tick_s;
  coord_t h_cnt_s;
  coord_t v_cnt_s;
  logic   h_wrap_s;
  logic   v_wrap_unused_s;
  logic   hs_win_s;
  logic   vs_win_s;

`ifdef VGA_PIX_DIV_EN
  coord_t div_r;

  // Pixel divider: a tick fires on the last clk of each pixel period.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_r <= 32'd0;
    end else if (tick_s) begin
      div_r <= 32'd0;
    end else begin
      div_r <= div_r + 32'd1;
    end
  end

  assign tick_s = (div_r == PIX_DIV - 32'd1);
`else
  assign tick_s = 1'b1;
`endif

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_axis (
    .clk(clk), .rst(rst), .en(tick_s), .wrap_in(1'b1),
    .count(h_cnt_s), .wrap_out(h_wrap_s), .sync_window(hs_win_s)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_axis (
    .clk(clk), .rst(rst), .en(h_wrap_s), .wrap_in(tick_s),
    .count(v_cnt_s), .wrap_out(v_wrap_unused_s), .sync_window(vs_win_s)
  );

  coord_t x_r;
  coord_t y_r;
  logic   active_r;
  logic   hsync_r;
  logic   vsync_r;
  logic   line_start_r;
  logic   frame_start_r;
  logic   pix_valid_r;

  // Output stage: snapshot the counter position on each tick, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r           <= 32'd0;
      y_r           <= 32'd0;
      active_r      <= 1'b0;
      hsync_r       <= ~HS_POL;
      vsync_r       <= ~VS_POL;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
      pix_valid_r   <= 1'b0;
    end else begin
      pix_valid_r <= tick_s;
      if (tick_s) begin
        x_r           <= h_cnt_s;
        y_r           <= v_cnt_s;
        active_r      <= (h_cnt_s < H_ACTIVE) && (v_cnt_s < V_ACTIVE);
        hsync_r       <= hs_win_s ? HS_POL : ~HS_POL;
        vsync_r       <= vs_win_s ? VS_POL : ~VS_POL;
        line_start_r  <= (h_cnt_s == 32'd0);
        frame_start_r <= (h_cnt_s == 32'd0) && (v_cnt_s == 32'd0);
      end
    end
  end

  assign x           = x_r;
  assign y           = y_r;
  assign active      = active_r;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign line_start  = line_start_r;
  assign frame_start = frame_start_r;
  assign pix_valid   = pix_valid_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced raster so whole frames fit the run.
module tb_vga_timing_gen;

  localparam int unsigned HA = 10, HF = 3, HS = 4, HB = 5;
  localparam int unsigned VA = 6,  VF = 2, VS = 3, VB = 2;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;
  localparam int unsigned FRAME = HT * VT;
`ifdef VGA_PIX_DIV_EN
  localparam int unsigned PD = 4;
`else
  localparam int unsigned PD = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] x, y;
  logic active, hsync, vsync, line_start, frame_start, pix_valid;

  always #5 clk = ~clk;

  vga_timing_gen #(
`ifdef VGA_PIX_DIV_EN
    .PIX_DIV(32'd4),
`endif
    .H_ACTIVE(32'd10), .H_FP(32'd3), .H_SYNC(32'd4), .H_BP(32'd5),
    .V_ACTIVE(32'd6),  .V_FP(32'd2), .V_SYNC(32'd3), .V_BP(32'd2),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .active(active), .hsync(hsync),
    .vsync(vsync), .line_start(line_start), .frame_start(frame_start),
    .pix_valid(pix_valid)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [71:0] got, input logic [71:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [71:0] pack(input logic [31:0] px, input logic [31:0] py,
                                       input logic a, input logic h, input logic v,
                                       input logic l, input logic f, input logic p);
    return {2'b00, px, py, a, h, v, l, f, p};
  endfunction

  // Reference model: predicts what the outputs hold after every rising edge.
  logic [71:0] sb[$];
  int unsigned m_h = 0, m_v = 0, m_div = 0;
  logic [31:0] e_x = 0, e_y = 0;
  logic e_act = 0, e_hs = 1, e_vs = 1, e_ls = 0, e_fs = 0, e_pv = 0;
  bit m_tick;

  always @(posedge clk) begin
    if (rst) begin
      m_h = 0; m_v = 0; m_div = 0;
      e_x = 0; e_y = 0; e_act = 0; e_hs = 1; e_vs = 1; e_ls = 0; e_fs = 0; e_pv = 0;
    end else begin
      m_tick = (m_div == PD - 1);
      m_div  = m_tick ? 0 : m_div + 1;
      e_pv   = m_tick;
      if (m_tick) begin
        e_x   = m_h;
        e_y   = m_v;
        e_act = (m_h < HA) && (m_v < VA);
        e_hs  = !((m_h >= HA + HF) && (m_h < HA + HF + HS));
        e_vs  = !((m_v >= VA + VF) && (m_v < VA + VF + VS));
        e_ls  = (m_h == 0);
        e_fs  = (m_h == 0) && (m_v == 0);
        if (m_h == HT - 1) begin
          m_h = 0;
          m_v = (m_v == VT - 1) ? 0 : m_v + 1;
        end else begin
          m_h = m_h + 1;
        end
      end
    end
    sb.push_back(pack(e_x, e_y, e_act, e_hs, e_vs, e_ls, e_fs, e_pv));
  end

  logic [71:0] sb_exp;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_exp = sb.pop_front();
      check_val("outputs", pack(x, y, active, hsync, vsync, line_start, frame_start, pix_valid), sb_exp);
    end
  end

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 16 && !ok; i++) begin
      @(negedge clk);
      if (pix_valid) ok = 1'b1;
    end
    check_val("tick_wait", 72'(ok), 72'(1));
  endtask

  bit ok, found;
  int unsigned last_fs, hlow, vlow;
  logic [31:0] px, py;

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_pins", 72'({hsync, vsync, active, pix_valid}), 72'(4'b1100));
    rst = 1'b0;
    last_fs = 0; hlow = 0; vlow = 0; px = 0; py = 0;
    for (int n = 0; n < 2 * FRAME + 2; n++) begin
      wait_tick(ok);
      if (!ok) break;
      if (n == 0)
        check_val("first_pix", 72'({x, y, active, line_start, frame_start}), {2'b00, 32'd0, 32'd0, 8'h07});
      if (frame_start && n > 0) begin
        check_val("frame_period", 72'(n - last_fs), 72'(FRAME));
        check_val("vs_width", 72'(vlow), 72'(VS * HT));
        check_val("wrap", {8'h00, px, py}, {8'h00, 32'(HT - 1), 32'(VT - 1)});
        vlow = 0;
        last_fs = n;
      end
      if (!hsync) hlow++;
      if (!vsync) vlow++;
      if (x == HA) check_val("active_drop", 72'(active), 72'(0));
      if (x == 0 && y == 1) check_val("line2_start", 72'(line_start), 72'(1));
      if (x == HT - 1) begin
        check_val("hs_width", 72'(hlow), 72'(HS));
        hlow = 0;
      end
      px = x; py = y;
    end

    found = 1'b0;
    for (int i = 0; i < FRAME + 1 && !found; i++) begin
      wait_tick(ok);
      if (!ok) break;
      if (x == 5 && y == 3) found = 1'b1;
    end
    check_val("mid_found", 72'(found), 72'(1));
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("mid_rst", pack(x, y, active, hsync, vsync, line_start, frame_start, pix_valid),
              pack(32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;
    wait_tick(ok);
    check_val("restart", pack(x, y, active, hsync, vsync, line_start, frame_start, pix_valid),
              pack(32'd0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator for the VGA output path.
- Sweeps pixel and line counters over a full frame, including blanking.
- Drives hsync/vsync pins and presents the current pixel coordinate (x, y) plus an active-video flag to the downstream pixel-test stages (segment/digit renderers).
- Those stages are combinational on (x, y). Their OR-ed hit, gated by active, becomes the colour output.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, asserted level of hsync (0 = active-low)
- VS_POL, 0, asserted level of vsync
- PIX_DIV, 4, clk cycles per pixel; used only when VGA_PIX_DIV_EN is defined

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- x  out  32  current pixel column (raw counter, 0..H_TOTAL-1)
- y  out  32  current line (raw counter, 0..V_TOTAL-1)
- active  out  1  (x < H_ACTIVE) & (y < V_ACTIVE)
- hsync  out  1  horizontal sync pin level
- vsync  out  1  vertical sync pin level
- line_start  out  1  one-pixel pulse when x == 0
- frame_start  out  1  one-pixel pulse when x == 0 and y == 0
- pix_valid  out  1  high on clk cycles where a new pixel is presented

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800). V_TOTAL is defined the same way (default 525). All arithmetic is 32-bit unsigned.
- Internal counters h_cnt and v_cnt.
  - On a pixel tick, h_cnt increments.
  - At h_cnt == H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - At v_cnt == V_TOTAL-1 on that same wrap, v_cnt wraps to 0.
- Output stage: every output is registered from (h_cnt, v_cnt) on each tick. All outputs describe the same position. Latency is 1 clk from counter to outputs.
- hsync = HS_POL when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, else !HS_POL. vsync is defined likewise on y with the V_* parameters.
- x and y are not clamped during blanking. Consumers must gate with active.
- Reset behaviour:
  - While rst is high: h_cnt = v_cnt = 0, x = y = 0, active = 0, line_start = frame_start = 0, pix_valid = 0, hsync = !HS_POL, vsync = !VS_POL.
  - On the first clk after rst deasserts (first tick), outputs present (0,0) with active = 1, line_start = 1 and frame_start = 1.
- Reset mid-frame abandons the frame. There is no partial-line completion. The timing restarts at (0,0) as above.
- Without VGA_PIX_DIV_EN, every clk is a tick and pix_valid = 1 after reset.

Optional Feature:
- Macro: VGA_PIX_DIV_EN.
- Defined:
  - A divider counter runs 0..PIX_DIV-1, reset to 0.
  - A tick occurs when the divider equals PIX_DIV-1.
  - Counters and output registers update only on a tick and hold otherwise.
  - pix_valid is high for exactly one clk per tick, on the cycle the new outputs appear.
  - line_start and frame_start stay high for the whole pixel period (PIX_DIV clks).
  - PIX_DIV = 1 behaves identically to the macro being undefined.
- Undefined: no divider logic; a tick occurs every clk.

Decomposition:
- Package vga_timing_pkg:
  - coord_t (logic [31:0]).
  - Default 640x480@60 timing constants.
  - H_TOTAL/V_TOTAL helper functions.
- Sub-module vga_axis_counter, instantiated once per axis:
  - Inputs: en, wrap_in.
  - Outputs: count, wrap_out, sync_window.
  - Parameterised by ACTIVE/FP/SYNC/BP.
  - The horizontal instance's wrap_out drives the vertical instance's en.

Test Plan:
- Reset, then release → first pixel x=0, y=0, active=1, frame_start=1, line_start=1; during reset hsync=vsync=1, active=0.
- Run one line → x rises 0..799, then x=0 with y=1 and line_start=1; active drops at x=640.
- hsync check → hsync=0 for exactly x=656..751 (96 pixels) on every line; vsync=0 only for y=490..491, i.e. 1600 pixels.
- Frame period → consecutive frame_start pulses are 420000 ticks apart; y wraps 524→0 together with x 799→0.
- Reset mid-frame at (300,200) for 3 clks → outputs go to reset values, then restart at (0,0) with frame_start=1.
- With VGA_PIX_DIV_EN and PIX_DIV=4 → pix_valid pulses every 4th clk; x advances only on those clks; frame_start stays high for 4 clks.
